// File: rtl/speed_display_driver_if.sv
// Load/status handshake between the speed-select logic and speed_display_driver.
// The master side drives value/load, and the slave side returns busy/overflow.
interface speed_display_driver_if #(
  parameter int VALUE_W = 7
) ();
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               busy;
  logic               overflow;

  modport master (output value, output load, input busy, input overflow);
  modport slave  (input value, input load, output busy, output overflow);
endinterface

// File: rtl/speed_display_driver.sv
// Binary-to-BCD (double-dabble) converter driving NUM_DIGITS multiplexed common-anode digits.
// Optional leading-zero blanking is enabled by defining SPEED_DISPLAY_LZB_EN.
module speed_display_driver #(
  parameter int NUM_DIGITS = 2,
  parameter int VALUE_W    = 7,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  speed_display_driver_if.slave   bus,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          CNT_W   = $clog2(VALUE_W + 1);
  localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          PRE_W   = $clog2(SCAN_DIV);
  localparam logic [31:0] MAX_VAL = 32'(10**NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                   state_reg;
  logic [VALUE_W-1:0]       shreg_reg;
  logic [BCD_W-1:0]         bcd_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic                     ovf_pending_reg;
  logic                     busy_reg;
  logic                     overflow_reg;
  logic [3:0]               disp_reg [NUM_DIGITS];
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+VALUE_W-1:0] shift_next;
  logic [6:0]               dig_seg [NUM_DIGITS];

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                  : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shift_next   = {bcd_adj, shreg_reg} << 1;
  assign bus.busy     = busy_reg;
  assign bus.overflow = overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      bcd_reg         <= '0;
      cnt_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      busy_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) disp_reg[i] <= 4'hF;
    end else begin
      case (state_reg)
        IDLE: if (bus.load) begin
          shreg_reg       <= bus.value;
          bcd_reg         <= '0;
          cnt_reg         <= CNT_W'(VALUE_W);
          ovf_pending_reg <= {{(32-VALUE_W){1'b0}}, bus.value} > MAX_VAL;
          busy_reg        <= 1'b1;
          state_reg       <= SHIFT;
        end
        SHIFT: begin
          {bcd_reg, shreg_reg} <= shift_next;
          cnt_reg              <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) disp_reg[i] <= bcd_reg[4*i +: 4];
          overflow_reg <= ovf_pending_reg;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SPEED_DISPLAY_LZB_EN
  // zero_above[i]: digit i and every digit above it are zero.
  logic [NUM_DIGITS:0] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      assign zero_above[gi] = zero_above[gi+1] && (disp_reg[gi] == 4'd0);
      assign dig_seg[gi] = overflow_reg                ? 7'b0111111 :
                           ((gi != 0) && zero_above[gi]) ? 7'b1111111 :
                                                         decode(disp_reg[gi]);
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      assign dig_seg[gi] = overflow_reg ? 7'b0111111 : decode(disp_reg[gi]);
    end
  endgenerate
`endif

  logic [PRE_W-1:0] presc_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic             wrap;

  assign wrap     = (presc_reg == PRE_W'(SCAN_DIV - 1));
  assign idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);

  // seg/an only change on a wrap, so a commit appears at the next scan slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= '0;
      seg       <= 7'b1111111;
      an        <= '1;
    end else begin
      presc_reg <= wrap ? '0 : presc_reg + PRE_W'(1);
      if (wrap) begin
        idx_reg <= idx_next;
        an      <= ~(NUM_DIGITS'(1) << idx_next);
        seg     <= dig_seg[idx_next];
      end
    end
  end
endmodule

// File: doc/speed_display_driver.md
Name: speed_display_driver

Overview:
- Parametrised successor to the single-digit speed decoder.
- Accepts a binary speed value and converts it to BCD sequentially with a shift-add-3 (double-dabble) engine.
- Time-multiplexes NUM_DIGITS common-anode 7-segment digits, each using the abcdefg, active-low segment encoding.
- Sits between the stepper speed-select logic and the board display pins.

Parameters:
- NUM_DIGITS, 2, number of displayed digits (1..4); digit 0 is the rightmost (units) digit.
- VALUE_W, 7, width of the binary value input (1..14).
- SCAN_DIV, 50000, clk cycles per digit-scan slot (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  VALUE_W  unsigned binary value to display; sampled only on an accepted load.
- load  in  1  single-cycle strobe requesting conversion of value.
- busy  out  1  high while a conversion is in progress; load is ignored while busy is high.
- overflow  out  1  high while the displayed value exceeds 10^NUM_DIGITS-1.
- seg  out  7  segment drive, abcdefg, active-low (1 = segment off).
- an  out  NUM_DIGITS  digit enables, one-hot, active-low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- All state is reset asynchronously when rst_n=0.
- Reset values:
  - seg=7'b1111111, an=all ones, busy=0, overflow=0.
  - FSM=IDLE.
  - Display digit registers hold the blank code.
  - Scan index=0, prescaler=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on a clk edge with load=1:
  - Capture value into the shift register and clear the BCD accumulator (4*NUM_DIGITS bits).
  - Set bit counter=VALUE_W.
  - Latch ovf_pending = (value > 10^NUM_DIGITS-1), with the comparison done at full integer width.
  - busy=1, next state SHIFT.
- SHIFT: each edge performs one step:
  - Add 3 to every BCD nibble >=5.
  - Shift {bcd, shreg} left by one.
  - Decrement the counter.
  - When the counter reaches 1 on this edge, go to COMMIT.
  - SHIFT therefore lasts exactly VALUE_W cycles.
- COMMIT: one edge:
  - Copy the BCD nibbles into the display registers.
  - overflow <= ovf_pending, busy <= 0, state goes to IDLE.
- Latency: a load accepted at edge E0 gives new display registers and busy=0 after edge E(VALUE_W+1).
- load while busy=1 (including during COMMIT) is dropped; no queueing.
- load held high in IDLE is accepted once per IDLE entry. The next acceptance is at the first IDLE edge after COMMIT.
- Overflow display: when overflow=1, every digit shows dash (g only: 7'b0111111), overriding the BCD.
- Digit decode: nibbles 0-9 use the standard active-low abcdefg codes (0=7'b1000000, 1=7'b1111001, ... 9=7'b0010000). Any other code gives blank (7'b1111111).
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the scan index advances modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - On the same edge, seg and an are registered:
    - an <= ~(1<<index_next).
    - seg <= the decoded digit at index_next.
  - seg and an are glitch-free and change only on a prescaler wrap.
- A display update in COMMIT becomes visible at the next scan slot. The scan sequence is not restarted.
- Reset asserted mid-conversion aborts the conversion and returns everything to reset values. Display blanking persists until the first scan wrap after reset.
- NUM_DIGITS=1: an is a constant 0 after the first wrap, and the index stays at 0.

Optional Feature:
- Macro: SPEED_DISPLAY_LZB_EN.
- Defined: leading-zero blanking.
  - Any digit above the most significant non-zero digit is driven blank (7'b1111111).
  - Digit 0 always shows, so value 0 displays "0".
  - Overflow dashes are unaffected.
- Undefined: all digits display, including leading zeros (e.g. value 7 with NUM_DIGITS=2 shows "07").

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release → seg=7'h7F, an=2'b11, busy=0, overflow=0 until the first wrap (SCAN_DIV=4 in the bench).
- NUM_DIGITS=2, VALUE_W=7; load=1 with value=42 for one cycle → busy=1 for exactly 8 cycles. Scan then shows digit0 seg=7'b0100100 with an=2'b10, and digit1 seg=7'b0011001 with an=2'b01.
- value=127 load → overflow=1 after 8 cycles, and both digits show 7'b0111111. Then a load of value=99 → overflow=0 and both digits show 7'b0010000.
- Issue load with value=30 and, 3 cycles later, load with value=55 → the second load is ignored and the display shows 30. The final busy fall occurs 8 cycles after the first load.
- Assert rst_n=0 during the 4th SHIFT cycle of value=88 → all outputs return to reset values. The display registers stay blank, and there is no commit after release.
- With SPEED_DISPLAY_LZB_EN defined: value=7 → digit1 is blank (7'h7F) and digit0 shows 7'b1111000. value=0 → digit0 shows 7'b1000000.
